padbi_seq_ctl: RTL and testbench



---
 rtl/padbi_seq_ctl.sv | 149 ++++++++++++++
 tb/tb_padbi_seq_ctl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/padbi_seq_ctl.sv
// Bidirectional pad-group sequencer: arbitrates core write/read requests,
// drives pad EN/DIR with turnaround dead cycles, holds write data, captures read data.
module padbi_seq_ctl #(
   parameter int M        = 7,
   parameter int N        = 0,
   parameter int TURN_CYC = 1,
   parameter int WR_HOLD  = 2,
   parameter int RD_WAIT  = 2
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       WR_REQ,
   input  logic [M:N] WR_DATA,
   output logic       WR_ACK,
   input  logic       RD_REQ,
   output logic [M:N] RD_DATA,
   output logic       RD_ACK,
   output logic       BUSY,
   output logic       EN,
   output logic       DIR,
   output logic [M:N] BISIG_OUT,
   input  logic [M:N] BISIG_IN
);

   localparam int MAX_TW = (TURN_CYC > WR_HOLD) ? TURN_CYC : WR_HOLD;
   localparam int MAXC   = (MAX_TW > RD_WAIT) ? MAX_TW : RD_WAIT;
   localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;

   localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYC - 1);
   localparam logic [CW-1:0] WR_LD   = CW'(WR_HOLD - 1);
   localparam logic [CW-1:0] RD_LD   = CW'(RD_WAIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_TURN,
      S_DRIVE,
      S_SAMPLE
   } state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          dir_q, dir_d;
   logic          en_q, en_d;
   logic          busy_q, busy_d;
   logic          wack_q, wack_d;
   logic          rack_q, rack_d;
   logic          last_wr_q, last_wr_d;
   logic          pend_wr_q, pend_wr_d;
   logic [M:N]    bout_q, bout_d;
   logic [M:N]    rdat_q, rdat_d;
   logic          gnt_wr;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         dir_q     <= 1'b0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         wack_q    <= 1'b0;
         rack_q    <= 1'b0;
         last_wr_q <= 1'b0;
         pend_wr_q <= 1'b0;
         bout_q    <= '0;
         rdat_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         dir_q     <= dir_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         wack_q    <= wack_d;
         rack_q    <= rack_d;
         last_wr_q <= last_wr_d;
         pend_wr_q <= pend_wr_d;
         bout_q    <= bout_d;
         rdat_q    <= rdat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      dir_d     = dir_q;
      wack_d    = 1'b0;
      rack_d    = 1'b0;
      last_wr_d = last_wr_q;
      pend_wr_d = pend_wr_q;
      bout_d    = bout_q;
      rdat_d    = rdat_q;
      gnt_wr    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            // An ack cycle never accepts, so a held REQ re-arbitrates next cycle
            if (!wack_q && !rack_q && (WR_REQ || RD_REQ)) begin
               gnt_wr    = WR_REQ && !(RD_REQ && last_wr_q);
               last_wr_d = gnt_wr;
               pend_wr_d = gnt_wr;
               if (gnt_wr) bout_d = WR_DATA;
               if (dir_q == gnt_wr) begin
                  state_d = gnt_wr ? S_DRIVE : S_SAMPLE;
                  cnt_d   = gnt_wr ? WR_LD : RD_LD;
               end else begin
                  state_d = S_TURN;
                  dir_d   = gnt_wr;
                  cnt_d   = TURN_LD;
               end
            end
         end
         S_TURN: begin
            if (cnt_q == '0) begin
               state_d = pend_wr_q ? S_DRIVE : S_SAMPLE;
               cnt_d   = pend_wr_q ? WR_LD : RD_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_DRIVE: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               wack_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_SAMPLE: begin
            if (cnt_q == '0) begin
               state_d = S_IDLE;
               rack_d  = 1'b1;
               rdat_d  = BISIG_IN;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      en_d   = (state_d == S_DRIVE) || (state_d == S_SAMPLE);
      busy_d = (state_d != S_IDLE);
   end

   assign EN        = en_q;
   assign DIR       = dir_q;
   assign BUSY      = busy_q;
   assign WR_ACK    = wack_q;
   assign RD_ACK    = rack_q;
   assign BISIG_OUT = bout_q;
   assign RD_DATA   = rdat_q;

endmodule

// File: tb/tb_padbi_seq_ctl.sv
// Bench for padbi_seq_ctl: default build (u0) and TURN=3/HOLD=1/WAIT=4 build (u1),
// each checked every cycle against a transaction-schedule model plus literal points.
module tb_padbi_seq_ctl;

   logic       clk = 1'b0;
   logic       rst[2];
   logic       wr_req[2];
   logic       rd_req[2];
   logic [7:0] wr_data[2];
   logic [7:0] bisig_in[2];
   logic       wack[2];
   logic       rack[2];
   logic       busy[2];
   logic       en[2];
   logic       dir[2];
   logic [7:0] rd_data[2];
   logic [7:0] bout[2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   padbi_seq_ctl u0 (
      .CLK(clk), .RESET(rst[0]),
      .WR_REQ(wr_req[0]), .WR_DATA(wr_data[0]), .WR_ACK(wack[0]),
      .RD_REQ(rd_req[0]), .RD_DATA(rd_data[0]), .RD_ACK(rack[0]),
      .BUSY(busy[0]), .EN(en[0]), .DIR(dir[0]),
      .BISIG_OUT(bout[0]), .BISIG_IN(bisig_in[0])
   );

   padbi_seq_ctl #(.TURN_CYC(3), .WR_HOLD(1), .RD_WAIT(4)) u1 (
      .CLK(clk), .RESET(rst[1]),
      .WR_REQ(wr_req[1]), .WR_DATA(wr_data[1]), .WR_ACK(wack[1]),
      .RD_REQ(rd_req[1]), .RD_DATA(rd_data[1]), .RD_ACK(rack[1]),
      .BUSY(busy[1]), .EN(en[1]), .DIR(dir[1]),
      .BISIG_OUT(bout[1]), .BISIG_IN(bisig_in[1])
   );

   task automatic cmp(input string nm, input logic [7:0] got,
                      input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0h want %0h", nm, got, want);
      end
   endtask

   // Model: on accept, the whole transfer is planned as a list of output frames
   typedef struct packed {
      logic       en;
      logic       dir;
      logic       busy;
      logic       wack;
      logic       rack;
      logic [7:0] bout;
   } frame_t;

   frame_t     exp_f[2];
   logic [7:0] exp_rd[2];
   frame_t     plan[2][$];
   bit         mvalid[2] = '{0, 0};
   bit         last_wr[2];
   logic       pdir[2];
   int         tc[2] = '{1, 3};
   int         wh[2] = '{2, 1};
   int         rw[2] = '{2, 4};

   task automatic model_step(input int k);
      frame_t f;
      bit     g;
      if (rst[k]) begin
         exp_f[k]   = '0;
         exp_rd[k]  = 8'h00;
         plan[k].delete();
         last_wr[k] = 1'b0;
         mvalid[k]  = 1'b1;
         return;
      end
      if (plan[k].size() == 0 && !exp_f[k].wack && !exp_f[k].rack &&
          (wr_req[k] || rd_req[k])) begin
         g          = wr_req[k] && !(rd_req[k] && last_wr[k]);
         last_wr[k] = g;
         f          = exp_f[k];
         f.dir      = g;
         f.busy     = 1'b1;
         f.en       = 1'b0;
         f.wack     = 1'b0;
         f.rack     = 1'b0;
         if (g) f.bout = wr_data[k];
         if (exp_f[k].dir != g) repeat (tc[k]) plan[k].push_back(f);
         f.en = 1'b1;
         repeat (g ? wh[k] : rw[k]) plan[k].push_back(f);
         f.en   = 1'b0;
         f.busy = 1'b0;
         f.wack = g;
         f.rack = !g;
         plan[k].push_back(f);
      end
      if (plan[k].size() > 0) begin
         f = plan[k].pop_front();
         if (f.rack) exp_rd[k] = bisig_in[k];
      end else begin
         f      = exp_f[k];
         f.en   = 1'b0;
         f.busy = 1'b0;
         f.wack = 1'b0;
         f.rack = 1'b0;
      end
      exp_f[k] = f;
   endtask

   always @(posedge clk) begin
      model_step(0);
      model_step(1);
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mvalid[k]) begin
            cmp($sformatf("u%0d.en", k), en[k], exp_f[k].en);
            cmp($sformatf("u%0d.dir", k), dir[k], exp_f[k].dir);
            cmp($sformatf("u%0d.busy", k), busy[k], exp_f[k].busy);
            cmp($sformatf("u%0d.wack", k), wack[k], exp_f[k].wack);
            cmp($sformatf("u%0d.rack", k), rack[k], exp_f[k].rack);
            cmp($sformatf("u%0d.bout", k), bout[k], exp_f[k].bout);
            cmp($sformatf("u%0d.rdata", k), rd_data[k], exp_rd[k]);
            cmp($sformatf("u%0d.en_at_dir_change", k),
                en[k] && (dir[k] !== pdir[k]), 1'b0);
         end
         pdir[k] = dir[k];
      end
   end

   int acks[$];
   int ackc[$];
   bit en_tab[11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};

   initial begin
      rst      = '{1, 1};
      wr_req   = '{0, 0};
      rd_req   = '{0, 0};
      wr_data  = '{8'h00, 8'h00};
      bisig_in = '{8'h00, 8'h00};
      repeat (3) @(negedge clk);
      cmp("rst.en", en[0], 1'b0);
      cmp("rst.busy", busy[0], 1'b0);
      cmp("rst.rdata", rd_data[0], 8'h00);
      rst = '{0, 0};

      // Write from DIR=0: turnaround first
      wr_req[0]  = 1'b1;
      wr_data[0] = 8'hA5;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         cmp($sformatf("t1.en.c%0d", c), en[0], (c == 2 || c == 3));
         cmp($sformatf("t1.busy.c%0d", c), busy[0], (c <= 3));
         cmp($sformatf("t1.wack.c%0d", c), wack[0], (c == 4));
         if (c == 1) cmp("t1.dir", dir[0], 1'b1);
         if (c == 2) cmp("t1.bout", bout[0], 8'hA5);
      end
      wr_req[0] = 1'b0;
      @(negedge clk);

      // Second write: no turnaround
      wr_req[0]  = 1'b1;
      wr_data[0] = 8'h3C;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         cmp($sformatf("t2.en.c%0d", c), en[0], (c <= 2));
         cmp($sformatf("t2.wack.c%0d", c), wack[0], (c == 3));
         if (c == 1) cmp("t2.bout", bout[0], 8'h3C);
      end
      wr_req[0] = 1'b0;
      @(negedge clk);

      // Read from DIR=1
      rd_req[0]   = 1'b1;
      bisig_in[0] = 8'h5A;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         cmp($sformatf("t3.en.c%0d", c), en[0], (c == 2 || c == 3));
         cmp($sformatf("t3.rack.c%0d", c), rack[0], (c == 4));
         if (c == 1) cmp("t3.dir", dir[0], 1'b0);
         if (c == 4) cmp("t3.rdata", rd_data[0], 8'h5A);
         if (c == 3) cmp("t3.bout_kept", bout[0], 8'h3C);
      end
      rd_req[0]   = 1'b0;
      bisig_in[0] = 8'h11;
      @(negedge clk);

      // Both requests held from reset: W,R,W,R every 5 cycles
      rst[0]     = 1'b1;
      wr_req[0]  = 1'b1;
      rd_req[0]  = 1'b1;
      wr_data[0] = 8'h77;
      @(negedge clk);
      rst[0] = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk);
         if (wack[0]) begin
            acks.push_back(1);
            ackc.push_back(c);
         end
         if (rack[0]) begin
            acks.push_back(0);
            ackc.push_back(c);
         end
      end
      wr_req[0] = 1'b0;
      rd_req[0] = 1'b0;
      cmp("t4.nacks", 8'(acks.size()), 8'd6);
      for (int i = 0; i < 4 && i < acks.size(); i++) begin
         cmp($sformatf("t4.type%0d", i), 8'(acks[i]), 8'((i % 2) == 0));
         cmp($sformatf("t4.cyc%0d", i), 8'(ackc[i]), 8'(4 + 5 * i));
      end

      // Reset in the second DRIVE cycle
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0]     = 1'b0;
      wr_req[0]  = 1'b1;
      wr_data[0] = 8'hE7;
      repeat (3) @(negedge clk);
      cmp("t5.drive2.en", en[0], 1'b1);
      rst[0]    = 1'b1;
      wr_req[0] = 1'b0;
      @(negedge clk);
      rst[0] = 1'b0;
      cmp("t5.en", en[0], 1'b0);
      cmp("t5.dir", dir[0], 1'b0);
      cmp("t5.bout", bout[0], 8'h00);
      cmp("t5.busy", busy[0], 1'b0);
      cmp("t5.wack", wack[0], 1'b0);
      @(negedge clk);
      cmp("t5.wack_next", wack[0], 1'b0);

      // Long-turnaround build: read then write
      rd_req[1]   = 1'b1;
      bisig_in[1] = 8'h96;
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         cmp($sformatf("t6.en.c%0d", c), en[1], en_tab[c-1]);
         if (c == 5) begin
            cmp("t6.rack", rack[1], 1'b1);
            cmp("t6.rdata", rd_data[1], 8'h96);
            rd_req[1]  = 1'b0;
            wr_req[1]  = 1'b1;
            wr_data[1] = 8'hC3;
         end
         if (c == 7) cmp("t6.dir", dir[1], 1'b1);
         if (c == 10) cmp("t6.bout", bout[1], 8'hC3);
         if (c == 11) begin
            cmp("t6.wack", wack[1], 1'b1);
            wr_req[1] = 1'b0;
         end
      end
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
